// File: rtl/product_bcd_display.sv
// product_bcd_display: converts the multiplier's 16-bit product to BCD with a
// sequential double-dabble engine and drives a 4-digit, time-multiplexed,
// common-anode 7-segment display with the decimal result.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.

module product_bcd_display #(
   parameter int REFRESH_DIV = 100000,
   parameter int DATA_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] value,
   output logic              busy,
   output logic              ovf,
   output logic [6:0]        seg,
   output logic [3:0]        anodes
);

   localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(REFRESH_DIV - 1);
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [DATA_W-1:0]   r_bin;
   logic [19:0]         r_bcd;
   logic [3:0]          r_cnt;
   logic [15:0]         r_disp;
   logic                r_ovf;
   logic [SCAN_W-1:0]   r_scan;
   logic [1:0]          r_idx;
   logic [19:0]         w_adj;
   logic [3:0]          w_digit;
   logic [6:0]          w_seg_digit;
   logic                w_blank;

   // State register for the conversion sequencer.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples
      // pre-edge values; blocking here would create order-dependent races.
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic: IDLE -> SHIFT on load, 16 shifts, one COMMIT cycle.
   always_comb begin
      // NOTE: default assigned first so no path leaves w_next unassigned,
      // which would otherwise infer a latch.
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (load) w_next = ST_SHIFT;
         ST_SHIFT:  if (r_cnt == 4'd15) w_next = ST_COMMIT;
         ST_COMMIT: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < 5; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   // Conversion datapath and display register; loads are ignored while busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_disp <= '0;
         r_ovf  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (load) begin
                  r_bin <= value;
                  r_bcd <= '0;
                  r_cnt <= '0;
               end
            end
            ST_SHIFT: begin
               r_bcd <= {w_adj[18:0], r_bin[DATA_W-1]};
               r_bin <= {r_bin[DATA_W-2:0], 1'b0};
               r_cnt <= r_cnt + 4'd1;
            end
            ST_COMMIT: begin
               r_disp <= r_bcd[15:0];
               r_ovf  <= (r_bcd[19:16] != 4'd0);
            end
            default: ;
         endcase
      end
   end

   // Free-running digit scan: advance the digit index on each counter wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scan <= '0;
         r_idx  <= '0;
      end else if (r_scan == SCAN_MAX) begin
         r_scan <= '0;
         r_idx  <= r_idx + 2'd1;
      end else begin
         r_scan <= r_scan + SCAN_W'(1);
      end
   end

   assign w_digit = r_disp[4*r_idx +: 4];

   // Decimal digit to active-low {g,f,e,d,c,b,a} segment pattern.
   always_comb begin
      w_seg_digit = SEG_BLANK;
      case (w_digit)
         4'd0: w_seg_digit = 7'b1000000;
         4'd1: w_seg_digit = 7'b1111001;
         4'd2: w_seg_digit = 7'b0100100;
         4'd3: w_seg_digit = 7'b0110000;
         4'd4: w_seg_digit = 7'b0011001;
         4'd5: w_seg_digit = 7'b0010010;
         4'd6: w_seg_digit = 7'b0000010;
         4'd7: w_seg_digit = 7'b1111000;
         4'd8: w_seg_digit = 7'b0000000;
         4'd9: w_seg_digit = 7'b0010000;
         default: w_seg_digit = SEG_BLANK;
      endcase
   end

   // Leading-zero blanking: a digit is blank when it and all digits above are zero.
   always_comb begin
      w_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      case (r_idx)
         2'd3: w_blank = (r_disp[15:12] == 4'd0);
         2'd2: w_blank = (r_disp[15:8] == 8'd0);
         2'd1: w_blank = (r_disp[15:4] == 12'd0);
         default: w_blank = 1'b0;
      endcase
`else
      w_blank = 1'b0;
`endif
   end

   assign busy   = (r_state != ST_IDLE);
   assign ovf    = r_ovf;
   assign anodes = ~(4'b0001 << r_idx);
   assign seg    = r_ovf   ? SEG_DASH  :
                   w_blank ? SEG_BLANK : w_seg_digit;

endmodule

// File: tb/tb_product_bcd_display.sv
// Scoreboard bench for product_bcd_display (REFRESH_DIV=4). Stimulus pushes the
// expected busy length, ovf and per-digit segment codes; a monitor pops an entry
// each time busy falls, then scans all four digit slots and compares.

module tb_product_bcd_display;

   localparam int RDIV = 4;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SD = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] Z  = 7'b1111111;
`else
   localparam logic [6:0] Z  = S0;
`endif

   typedef struct {
      int              len;
      logic            ovf;
      logic [3:0][6:0] segs;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        load;
   logic [15:0] value;
   logic        busy;
   logic        ovf;
   logic [6:0]  seg;
   logic [3:0]  anodes;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_err  = 0;
   int   n_done = 0;
   int   n_push = 0;

   product_bcd_display #(.REFRESH_DIV(RDIV), .DATA_W(16)) dut (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .value  (value),
      .busy   (busy),
      .ovf    (ovf),
      .seg    (seg),
      .anodes (anodes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int len, input logic o, input logic [3:0][6:0] s);
      exp_t e;
      e.len  = len;
      e.ovf  = o;
      e.segs = s;
      q.push_back(e);
      n_push++;
   endtask

   // One-cycle load pulse captured on the posedge between the two negedges.
   task automatic do_load(input logic [15:0] v);
      @(negedge clk);
      load  = 1'b1;
      value = v;
      @(negedge clk);
      load  = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400 && n_done < n_push; i++) @(negedge clk);
      if (n_done < n_push) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_done: got %0d results, expected %0d", n_done, n_push);
      end
   endtask

   // Monitor: counts busy cycles, and on busy falling checks one scoreboard entry.
   initial begin
      int   blen;
      int   t;
      exp_t e;
      logic [3:0] pat;
      blen = 0;
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            blen++;
         end else if (blen != 0) begin
            if (q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_result: got busy pulse of %0d, expected none", blen);
            end else begin
               e = q.pop_front();
               check("busy_len", blen, e.len);
               check("ovf", ovf, e.ovf);
               for (int i = 0; i < 4; i++) begin
                  pat = ~(4'b0001 << i);
                  for (t = 0; t < 40 && anodes !== pat; t++) @(negedge clk);
                  if (anodes !== pat) begin
                     n_vec++;
                     n_err++;
                     $display("FAIL anode_slot%0d: got %b, expected %b", i, anodes, pat);
                  end else begin
                     check($sformatf("seg_digit%0d", i), seg, e.segs[i]);
                  end
               end
            end
            blen = 0;
            n_done++;
         end
      end
   end

   // Directed stimulus.
   initial begin
      logic [3:0] ea;
      reset = 1'b1;
      load  = 1'b0;
      value = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_anodes", anodes, 4'b1110);
      check("rst_seg", seg, S0);
      check("rst_busy", busy, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      reset = 1'b0;

      // Anode rotation, one step every RDIV clocks after reset release.
      for (int k = 0; k <= 16; k++) begin
         ea = ~(4'b0001 << ((k / RDIV) % 4));
         check($sformatf("scan_k%0d", k), anodes, ea);
         @(negedge clk);
      end

      push(17, 1'b0, {Z, Z, S4, S0});
      do_load(16'd40);
      wait_done();

      push(17, 1'b0, {Z, S5, S1, S0});
      do_load(16'd510);
      wait_done();

      push(17, 1'b1, {SD, SD, SD, SD});
      do_load(16'd12345);
      wait_done();

      push(17, 1'b0, {S9, S9, S9, S9});
      do_load(16'd9999);
      wait_done();

      // Second load three cycles after the first is dropped.
      push(17, 1'b0, {Z, S1, S4, S4});
      do_load(16'd144);
      repeat (2) @(negedge clk);
      load  = 1'b1;
      value = 16'd9;
      @(negedge clk);
      load  = 1'b0;
      wait_done();

      // Reset 8 cycles into a conversion aborts it and clears the display.
      push(8, 1'b0, {Z, Z, Z, S0});
      do_load(16'd255);
      repeat (8) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_anodes", anodes, 4'b1110);
      check("abort_seg", seg, S0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_done();

      push(17, 1'b0, {Z, Z, Z, S7});
      do_load(16'd7);
      wait_done();

      repeat (4) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time limit.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
